// File: rtl/relu_layer_ctrl_if.sv
// relu_layer_ctrl_if: layer start/status, accumulator read,
// ReLU operand/result and activation write bus.
interface relu_layer_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] relu_in;
    logic              relu_valid;
    logic [DATA_W-1:0] relu_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   nz_count;

    modport master (
        input  start, rd_data, relu_out,
        output busy, done, rd_en, rd_addr, relu_in,
        output relu_valid, wr_en, wr_addr, wr_data, nz_count
    );

    modport slave (
        output start, rd_data, relu_out,
        input  busy, done, rd_en, rd_addr, relu_in,
        input  relu_valid, wr_en, wr_addr, wr_data, nz_count
    );
endinterface

// File: rtl/relu_layer_ctrl.sv
// relu_layer_ctrl: walks one layer's accumulators through a 1-cycle ReLU unit.
// Optional ACT_CLAMP_EN bounds each activation at CLAMP_MAX (ReLU6-style).
module relu_layer_ctrl #(
    parameter int NUM_NEURONS = 32,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6
`ifdef ACT_CLAMP_EN
    ,
    parameter logic [DATA_W-1:0] CLAMP_MAX = 32'h0000_0600
`endif
) (
    input logic               clock,
    input logic               reset,
    relu_layer_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ACT,
        WR,
        FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   nz_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_q;
    logic              rv_q;
    logic              wr_q;
    logic [DATA_W-1:0] act;
    logic              last;

    assign last = (idx == ADDR_W'(NUM_NEURONS - 1));

    always_comb begin
`ifdef ACT_CLAMP_EN
        act = (bus.relu_out > CLAMP_MAX) ? CLAMP_MAX : bus.relu_out;
`else
        act = bus.relu_out;
`endif
    end

    // Strobes are registered against the state being entered,
    // so they line up exactly with the current state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            nz_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            rv_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            rv_q   <= 1'b0;
            wr_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx    <= '0;
                        nz_q   <= '0;
                        busy_q <= 1'b1;
                        rd_q   <= 1'b1;
                        state  <= RD;
                    end
                end
                RD: begin
                    rv_q  <= 1'b1;
                    state <= ACT;
                end
                ACT: begin
                    wr_q  <= 1'b1;
                    state <= WR;
                end
                WR: begin
                    if (act != '0) begin
                        nz_q <= nz_q + (ADDR_W+1)'(1);
                    end
                    if (last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        rd_q  <= 1'b1;
                        state <= RD;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rd_en      = rd_q;
    assign bus.rd_addr    = idx;
    assign bus.relu_in    = bus.rd_data;
    assign bus.relu_valid = rv_q;
    assign bus.wr_en      = wr_q;
    assign bus.wr_addr    = idx;
    assign bus.wr_data    = wr_q ? act : '0;
    assign bus.nz_count   = nz_q;

endmodule

// File: doc/relu_layer_ctrl.md
Name: relu_layer_ctrl

Overview:
- Sequences one layer's neuron accumulators through the shared single-cycle ReLU activation unit.
- Reads each pre-activation value from the accumulator buffer and drives the ReLU unit. Writes the activated result to the activation buffer.
- Counts non-zero activations for the downstream layer.
- Sits between the MAC array's accumulator RAM and the next layer's input RAM. Started once per layer by the top-level layer sequencer.

Parameters:
- NUM_NEURONS, 32, neurons per layer; legal range 1..2**ADDR_W
- DATA_W, 32, signed two's-complement data width; MSB is the sign bit
- ADDR_W, 6, buffer address width
- CLAMP_MAX, 32'h0000_0600, positive clamp ceiling; used only with ACT_CLAMP_EN

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last write completes
- rd_en  out  1  accumulator buffer read strobe
- rd_addr  out  ADDR_W  accumulator read address
- rd_data  in  DATA_W  read data, valid the cycle after rd_en (fixed 1-cycle RAM latency)
- relu_in  out  DATA_W  operand to the ReLU unit; equals rd_data
- relu_valid  out  1  ReLU enable strobe
- relu_out  in  DATA_W  ReLU result, valid the cycle after relu_valid
- wr_en  out  1  activation buffer write strobe
- wr_addr  out  ADDR_W  activation write address
- wr_data  out  DATA_W  activation write data
- nz_count  out  ADDR_W+1  number of non-zero activations written this layer

Behaviour:
- Reset (async, active-high): state=IDLE, idx=0, nz_count=0. busy, done, rd_en, relu_valid and wr_en are all 0.
- Address, data and enable outputs are Moore outputs decoded from state and idx. relu_in = rd_data combinationally.
- FSM states: IDLE, RD, ACT, WR, FIN.
- IDLE: on start=1, set idx=0, clear nz_count, go to RD. start while not in IDLE is ignored.
- RD: rd_en=1, rd_addr=idx. Next state is ACT.
- ACT: relu_valid=1. Next state is WR.
- WR: wr_en=1, wr_addr=idx, wr_data=relu_out.
  - If relu_out != 0, increment nz_count.
  - If idx==NUM_NEURONS-1, go to FIN; otherwise idx<=idx+1 and go to RD.
- FIN: done=1 for exactly one cycle, then go to IDLE. busy=0 in FIN.
- busy=1 in RD, ACT and WR.
- Throughput: 3 cycles per neuron. If start is sampled at edge 0, done is high during cycle 3*NUM_NEURONS+1.
- The ReLU unit's done flag is level-held and is not used for sequencing. Only the fixed 1-cycle latency is relied on.
- Each address is read once and written once, in ascending order with no wrap. idx never exceeds NUM_NEURONS-1.
- nz_count saturation is impossible because its width is ADDR_W+1. Its value holds after done until the next accepted start.
- start asserted in the FIN cycle is ignored. A new start is accepted from IDLE on the following cycle.
- reset mid-layer aborts immediately: all strobes drop in the same cycle, partial writes remain in the buffer, and nz_count=0.
- NUM_NEURONS=1: RD, ACT, WR, FIN; done is high in cycle 4.

Optional Feature:
- Macro: ACT_CLAMP_EN
- Defined: wr_data = (relu_out > CLAMP_MAX, unsigned compare) ? CLAMP_MAX : relu_out. This is a ReLU6-style bounded activation, adding combinational logic only with no latency change. nz_count is computed on the clamped value.
- Undefined: wr_data = relu_out unmodified; CLAMP_MAX is unused.

Test Plan:
- Basic layer, NUM_NEURONS=4, RAM={5, -3, 0, 0x7FFF_FFFF}, start pulse:
  - writes {5, 0, 0, 0x7FFF_FFFF} to addresses 0..3 in order
  - nz_count=2, done during cycle 13, busy high during cycles 1..12
- Timing check: rd_en at idx k is followed by relu_valid one cycle later and wr_en two cycles later, all with matching addr k. No two strobes are active in the same cycle.
- start held high for 20 cycles: exactly one layer runs, start is ignored while busy, and a second layer begins on the cycle after FIN.
- reset asserted during the ACT cycle of idx 2:
  - all outputs return to 0 asynchronously and no wr_en for idx 2 occurs
  - a subsequent start reprocesses from address 0
- ACT_CLAMP_EN defined, RAM={0x700, 0x100, -1, 0x600}: writes {0x600, 0x100, 0, 0x600}, nz_count=3.
- NUM_NEURONS=1, RAM={-8}: writes 0, nz_count=0, done in cycle 4.
